// File: rtl/ppu_mode_sequencer_if.sv
// ppu_mode_sequencer_if
//   Bundles the control inputs and the timing outputs of the PPU mode
//   sequencer. The master side is the register file / pixel FIFO that drives
//   the strobes and register values. The slave side is the sequencer itself.
//   Inputs : tclk_in, lcd_en_in, window_ena_in, pixel_valid_in, WY_in, LYC_in,
//            stat_sel_in
//   Outputs: mode_out, X_out, Y_out, dot_out, draw_en_out, WY_cond_out,
//            lyc_eq_out, oam_scan_start_out, vblank_irq_out, stat_irq_out,
//            overrun_out
interface ppu_mode_sequencer_if #(
  parameter int XW = 8,
  parameter int YW = 8
);
  logic          tclk_in;
  logic          lcd_en_in;
  logic          window_ena_in;
  logic          pixel_valid_in;
  logic [7:0]    WY_in;
  logic [7:0]    LYC_in;
  logic [3:0]    stat_sel_in;
  logic [1:0]    mode_out;
  logic [XW-1:0] X_out;
  logic [YW-1:0] Y_out;
  logic [8:0]    dot_out;
  logic          draw_en_out;
  logic          WY_cond_out;
  logic          oam_scan_start_out;
  logic          lyc_eq_out;
  logic          vblank_irq_out;
  logic          stat_irq_out;
  logic          overrun_out;

  modport master (
    output tclk_in, lcd_en_in, window_ena_in, pixel_valid_in, WY_in, LYC_in, stat_sel_in,
    input  mode_out, X_out, Y_out, dot_out, draw_en_out, WY_cond_out, oam_scan_start_out,
           lyc_eq_out, vblank_irq_out, stat_irq_out, overrun_out
  );

  modport slave (
    input  tclk_in, lcd_en_in, window_ena_in, pixel_valid_in, WY_in, LYC_in, stat_sel_in,
    output mode_out, X_out, Y_out, dot_out, draw_en_out, WY_cond_out, oam_scan_start_out,
           lyc_eq_out, vblank_irq_out, stat_irq_out, overrun_out
  );
endinterface

// File: rtl/ppu_mode_sequencer.sv
// ppu_mode_sequencer
//   Scanline/frame timing controller. It counts T-cycle dots and scanlines,
//   and it steps through the PPU modes OAM scan (2), drawing (3), HBlank (0)
//   and VBlank (1). It drives the X/Y render counters, draw enable and the
//   window-Y condition, and it raises the VBlank, STAT and overrun pulses.
//   Ports:
//     clk_in  - system clock
//     rst_in  - asynchronous active-high reset
//     bus     - ppu_mode_sequencer_if.slave (strobes/registers in, timing out)
//   All outputs are registered. Pulses are one clk_in wide.
module ppu_mode_sequencer #(
  parameter int X_MAX           = 160,
  parameter int Y_VISIBLE       = 144,
  parameter int TOTAL_SCANLINES = 154,
  parameter int DOTS_PER_LINE   = 456,
  parameter int OAM_DOTS        = 80
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  ppu_mode_sequencer_if.slave  bus
);
  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(TOTAL_SCANLINES);
  localparam logic [XW-1:0] X_LAST   = XW'(X_MAX - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(TOTAL_SCANLINES - 1);
  localparam logic [YW-1:0] Y_VBL    = YW'(Y_VISIBLE);
  localparam logic [8:0]    DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0]    OAM_LAST = 9'(OAM_DOTS - 1);

  typedef enum logic [1:0] {
    M_HBLANK = 2'd0,
    M_VBLANK = 2'd1,
    M_OAM    = 2'd2,
    M_DRAW   = 2'd3
  } mode_t;

  mode_t         mode_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [8:0]    dot_q;
  logic          running_q, draw_q, wy_q, lyc_q;
  logic          oam_q, vbl_q, stat_q, ovr_q, stat_line_q;

  logic          line_start, stat_line;
  logic [YW-1:0] y_new;

  // A line starts on the first strobe after enable, or on the last dot.
  assign line_start = bus.tclk_in && (!running_q || dot_q == DOT_LAST);
  assign y_new      = (!running_q || y_q == Y_LAST) ? '0 : y_q + YW'(1);

  // The STAT line is built from the registered state. Its rising edge is the
  // interrupt, so sources that overlap merge into one pulse.
  assign stat_line = (bus.stat_sel_in[3] && lyc_q) ||
                     (bus.stat_sel_in[2] && mode_q == M_OAM) ||
                     (bus.stat_sel_in[1] && mode_q == M_VBLANK) ||
                     (bus.stat_sel_in[0] && mode_q == M_HBLANK && running_q);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_q <= M_HBLANK; x_q <= '0; y_q <= '0; dot_q <= '0;
      running_q <= 1'b0; draw_q <= 1'b0; wy_q <= 1'b0; lyc_q <= 1'b0;
      oam_q <= 1'b0; vbl_q <= 1'b0; stat_q <= 1'b0; ovr_q <= 1'b0; stat_line_q <= 1'b0;
    end else if (!bus.lcd_en_in) begin
      mode_q <= M_HBLANK; x_q <= '0; y_q <= '0; dot_q <= '0;
      running_q <= 1'b0; draw_q <= 1'b0; wy_q <= 1'b0; lyc_q <= 1'b0;
      oam_q <= 1'b0; vbl_q <= 1'b0; stat_q <= 1'b0; ovr_q <= 1'b0; stat_line_q <= 1'b0;
    end else begin
      oam_q <= 1'b0;
      vbl_q <= 1'b0;
      ovr_q <= 1'b0;
      // lyc_eq follows Y_out one clk later. A new line therefore drops the
      // mode-0 STAT source before the LYC source can rise, and that gap
      // makes the LYC match produce its own edge.
      lyc_q       <= running_q && (y_q == bus.LYC_in);
      stat_line_q <= stat_line;
      stat_q      <= stat_line && !stat_line_q;

      if (line_start) begin
        // The line start takes priority: a pixel that arrives in the same
        // clk is dropped.
        running_q <= 1'b1;
        dot_q     <= '0;
        x_q       <= '0;
        y_q       <= y_new;
        draw_q    <= 1'b0;
        ovr_q     <= running_q && (mode_q == M_DRAW);
        if (y_new < Y_VBL) begin
          mode_q <= M_OAM;
          oam_q  <= 1'b1;
          // The frame-start line clears the condition before its own check.
          wy_q   <= (wy_q && (y_new != '0)) ||
                    (bus.window_ena_in && (y_new == bus.WY_in));
        end else begin
          mode_q <= M_VBLANK;
          vbl_q  <= (y_new == Y_VBL);
        end
      end else begin
        if (bus.tclk_in && running_q)
          dot_q <= dot_q + 9'd1;
        if (bus.tclk_in && running_q && mode_q == M_OAM && dot_q == OAM_LAST) begin
          mode_q <= M_DRAW;
          draw_q <= 1'b1;
        end else if (bus.pixel_valid_in && mode_q == M_DRAW) begin
          // X holds at the last pixel. HBlank starts on the next clk.
          if (x_q == X_LAST) begin
            mode_q <= M_HBLANK;
            draw_q <= 1'b0;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
      end
    end
  end

  assign bus.mode_out           = mode_q;
  assign bus.X_out              = x_q;
  assign bus.Y_out              = y_q;
  assign bus.dot_out            = dot_q;
  assign bus.draw_en_out        = draw_q;
  assign bus.WY_cond_out        = wy_q;
  assign bus.lyc_eq_out         = lyc_q;
  assign bus.oam_scan_start_out = oam_q;
  assign bus.vblank_irq_out     = vbl_q;
  assign bus.stat_irq_out       = stat_q;
  assign bus.overrun_out        = ovr_q;
endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// tb_ppu_mode_sequencer
//   Scoreboard bench for ppu_mode_sequencer. The stimulus pushes the expected
//   pulse records and state snapshots. A monitor on the falling clock edge
//   pops a pulse record whenever any pulse output is high, and it pops a
//   snapshot whenever the stimulus requests one.
module tb_ppu_mode_sequencer;
  localparam int LYC = 5;
  localparam int WY  = 10;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  ppu_mode_sequencer_if #(.XW(8), .YW(8)) b();
  ppu_mode_sequencer dut (.clk_in(clk_in), .rst_in(rst_in), .bus(b));

  // p = {oam_scan_start, vblank_irq, stat_irq, overrun}
  typedef struct { logic [3:0] p; int y; int mode; int dot; } ev_t;
  typedef struct { int mode; int x; int y; int dot; bit draw; bit wyc; bit lyc; } snap_t;

  ev_t   ev_q[$];
  snap_t snap_q[$];
  bit    snap_req  = 1'b0;
  bit    final_req = 1'b0;
  int    checks = 0;
  int    errors = 0;
  ev_t        e;
  snap_t      s;
  logic [3:0] pulses;

  always @(negedge clk_in) begin
    pulses = {b.oam_scan_start_out, b.vblank_irq_out, b.stat_irq_out, b.overrun_out};
    if (pulses != 4'b0) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected got p=%b Y=%0d mode=%0d dot=%0d, none expected",
                 pulses, b.Y_out, b.mode_out, b.dot_out);
      end else begin
        e = ev_q.pop_front();
        if (e.p != pulses || e.y != int'(b.Y_out) || e.mode != int'(b.mode_out) ||
            e.dot != int'(b.dot_out)) begin
          errors++;
          $display("FAIL pulse got p=%b Y=%0d mode=%0d dot=%0d want p=%b Y=%0d mode=%0d dot=%0d",
                   pulses, b.Y_out, b.mode_out, b.dot_out, e.p, e.y, e.mode, e.dot);
        end
      end
    end
    if (snap_req && snap_q.size() != 0) begin
      s = snap_q.pop_front();
      checks++;
      if (s.mode != int'(b.mode_out) || s.x != int'(b.X_out) || s.y != int'(b.Y_out) ||
          s.dot != int'(b.dot_out) || s.draw != b.draw_en_out || s.wyc != b.WY_cond_out ||
          s.lyc != b.lyc_eq_out) begin
        errors++;
        $display("FAIL state got mode=%0d X=%0d Y=%0d dot=%0d draw=%0b wy=%0b lyc=%0b want mode=%0d X=%0d Y=%0d dot=%0d draw=%0b wy=%0b lyc=%0b",
                 b.mode_out, b.X_out, b.Y_out, b.dot_out, b.draw_en_out, b.WY_cond_out, b.lyc_eq_out,
                 s.mode, s.x, s.y, s.dot, s.draw, s.wyc, s.lyc);
      end
    end
    if (final_req) begin
      checks++;
      if (ev_q.size() != 0) begin
        errors++;
        $display("FAIL pulses_missing got pending=%0d want 0", ev_q.size());
      end
      checks++;
      if (snap_q.size() != 0) begin
        errors++;
        $display("FAIL snapshots_pending got pending=%0d want 0", snap_q.size());
      end
    end
  end

  task automatic tick(input bit t, input bit pv);
    b.tclk_in = t;
    b.pixel_valid_in = pv;
    @(posedge clk_in); #1;
    b.tclk_in = 1'b0;
    b.pixel_valid_in = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic push_ev(input logic [3:0] p, input int y, input int mode, input int dot);
    ev_t r;
    r.p = p; r.y = y; r.mode = mode; r.dot = dot;
    ev_q.push_back(r);
  endtask

  task automatic snap(input int mode, input int x, input int y, input int dot,
                      input bit draw, input bit wyc, input bit lyc);
    snap_t r;
    r.mode = mode; r.x = x; r.y = y; r.dot = dot; r.draw = draw; r.wyc = wyc; r.lyc = lyc;
    snap_q.push_back(r);
    snap_req = 1'b1;
  endtask

  // The first strobe after enable starts line 0 in mode 2.
  task automatic enable_start();
    push_ev(4'b1000, 0, 2, 0);
    tick(1'b1, 1'b0);
    snap(2, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // This task runs strobes for dots 0..last of line y. It starts from dot 0
  // of that line. Pixel lines push one pixel per strobe at dots 80..239, plus
  // stray pixels in modes 2 and 0 and at the line end, which must be ignored.
  task automatic run_line(input int y, input bit pix, input int last);
    bit vis, pv, wyc, lyc;
    int ny;
    logic [3:0] p;
    vis = (y < 144);
    wyc = (y >= WY);
    lyc = (y == LYC);
    for (int d = 0; d <= last; d++) begin
      pv = vis && ((pix && ((d >= 80 && d <= 239) || d == 60 || d == 300)) || d == 455);
      if (d == 239 && vis && pix && y != LYC) push_ev(4'b0010, y, 0, 241);
      if (d == 455) begin
        ny = (y + 1) % 154;
        p  = {ny < 144, ny == 144, 1'b0, vis && !pix};
        if (p != 4'b0) push_ev(p, ny, (ny < 144) ? 2 : 1, 0);
        if (ny == LYC) push_ev(4'b0010, ny, 2, 2);
      end
      tick(1'b1, pv);
      if (d == 0) snap(vis ? 2 : 1, 0, y, 1, 1'b0, wyc, lyc);
      if (vis && pix) begin
        if (d == 78)  snap(2, 0,   y, 79,  1'b0, wyc, lyc);
        if (d == 79)  snap(3, 0,   y, 80,  1'b1, wyc, lyc);
        if (d == 238) snap(3, 159, y, 239, 1'b1, wyc, lyc);
        if (d == 239) snap(0, 159, y, 240, 1'b0, wyc, lyc);
        if (d == 454) snap(0, 159, y, 455, 1'b0, wyc, lyc);
      end
      if (vis && !pix && d == 454) snap(3, 0, y, 455, 1'b1, wyc, lyc);
    end
  endtask

  initial begin
    b.tclk_in = 1'b0; b.lcd_en_in = 1'b0; b.window_ena_in = 1'b0; b.pixel_valid_in = 1'b0;
    b.WY_in = 8'd0; b.LYC_in = 8'd0; b.stat_sel_in = 4'd0;
    repeat (2) @(posedge clk_in);
    #1;
    snap(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    rst_in = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    snap(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);   // LCD off: the strobes are ignored
    tick(1'b0, 1'b0);

    b.LYC_in = 8'(LYC); b.stat_sel_in = 4'b1001; b.WY_in = 8'(WY); b.window_ena_in = 1'b1;
    b.lcd_en_in = 1'b1;
    enable_start();
    for (int y = 0; y <= 20; y++) run_line(y, y != 7, (y == 20) ? 99 : 455);

    // LCD drops in the middle of mode 3 on line 20.
    b.lcd_en_in = 1'b0;
    tick(1'b1, 1'b1);
    snap(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    b.lcd_en_in = 1'b1;
    tick(1'b0, 1'b0);
    snap(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    enable_start();

    // A full frame, ending with the wrap to Y=0.
    for (int y = 0; y < 154; y++) run_line(y, y != 7, 455);
    run_line(0, 1'b1, 0);
    tick(1'b1, 1'b0);

    // The reset must clear the outputs before the next clock edge.
    rst_in = 1'b1;
    snap(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);

    final_req = 1'b1;
    @(posedge clk_in); #1;
    final_req = 1'b0;
    @(posedge clk_in); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
